// File: rtl/hatch_imem_pkg.sv
// ---------------------------------------------------------------------------
// hatch_imem_pkg
// Shared definitions for the hatch instruction memory: instruction width in
// bytes, bank count, the loader state encoding and the small helpers that map
// a fetch address onto the eight byte-banks.
// ---------------------------------------------------------------------------
package hatch_imem_pkg;

   localparam int INSTR_BYTES = 6;
   localparam int NUM_BANKS   = 8;
   localparam int INSTR_W     = INSTR_BYTES * 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } load_state_t;

   // Bank holding byte number 'lane' of an instruction whose first byte sits
   // in bank 'addr_lsb'; banks are visited in ascending order and wrap at 8.
   function automatic logic [2:0] bank_index(input logic [2:0] addr_lsb,
                                             input int unsigned lane);
      return addr_lsb + 3'(lane);
   endfunction

   // A bank below the starting bank holds the tail of the window, which lives
   // one row further on than the starting row.
   function automatic logic row_bump(input logic [2:0] bank,
                                     input logic [2:0] addr_lsb);
      return bank < addr_lsb;
   endfunction

endpackage

// File: rtl/hatch_imem_if.sv
// ---------------------------------------------------------------------------
// hatch_imem_if
// Fetch and loader signal bundle for hatch_imem.
//   master : cpu / boot controller side (drives address and load stream)
//   slave  : memory side (returns instruction, valid, fault, loader status)
// Fetch : hatch_address, hatch_instruction, hatch_valid, hatch_fault
// Loader: load_start, load_base, load_valid, load_data, load_last,
//         load_ready, load_busy, load_count, load_error
// ---------------------------------------------------------------------------
interface hatch_imem_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   import hatch_imem_pkg::*;

   logic [ADDR_W-1:0]  hatch_address;
   logic [INSTR_W-1:0] hatch_instruction;
   logic               hatch_valid;
   logic               hatch_fault;

   logic               load_start;
   logic [ADDR_W-1:0]  load_base;
   logic               load_valid;
   logic [7:0]         load_data;
   logic               load_last;
   logic               load_ready;
   logic               load_busy;
   logic [CNT_W-1:0]   load_count;
   logic               load_error;

   modport master (
      output hatch_address, load_start, load_base, load_valid, load_data, load_last,
      input  hatch_instruction, hatch_valid, hatch_fault,
             load_ready, load_busy, load_count, load_error
   );

   modport slave (
      input  hatch_address, load_start, load_base, load_valid, load_data, load_last,
      output hatch_instruction, hatch_valid, hatch_fault,
             load_ready, load_busy, load_count, load_error
   );

endinterface

// File: rtl/hatch_imem_bank.sv
// ---------------------------------------------------------------------------
// hatch_imem_bank
// One byte-wide synchronous RAM bank: one write port, one registered read
// port. Contents are never reset.
//   clk   : clock
//   we    : write enable
//   waddr : write row
//   wdata : write byte
//   raddr : read row, sampled every edge
//   rdata : byte at raddr as of the previous edge
// ---------------------------------------------------------------------------
module hatch_imem_bank
   import hatch_imem_pkg::*;
#(
   parameter int ROWS  = 1024,
   parameter int ROW_W = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ROW_W-1:0] waddr,
   input  logic [7:0]       wdata,
   input  logic [ROW_W-1:0] raddr,
   output logic [7:0]       rdata
);

   logic [7:0] mem [ROWS];

   // Read and write share one edge; the read picks up the old byte when both
   // target the same row, so a freshly written byte shows up a sample later.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/hatch_imem.sv
// ---------------------------------------------------------------------------
// hatch_imem
// Byte-addressed instruction store on the responder side of the hatch fetch
// interface, with a streaming byte loader for program images.
//   clk : system clock
//   rst : asynchronous active-high reset (memory contents are kept)
//   bus : hatch_imem_if.slave
//         fetch  - hatch_address in; 6-byte hatch_instruction out one edge
//                  later, with hatch_valid and hatch_fault
//         loader - load_start/load_base begin a load, load_valid/load_data/
//                  load_last stream bytes, load_ready/load_busy/load_count/
//                  load_error report progress
// ---------------------------------------------------------------------------
module hatch_imem
   import hatch_imem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_BYTES = 8192,
   parameter int CNT_W       = 16
) (
   input logic         clk,
   input logic         rst,
   hatch_imem_if.slave bus
);

   localparam int LOG2_DEPTH = $clog2(DEPTH_BYTES);
   localparam int ROWS       = DEPTH_BYTES / NUM_BANKS;
   localparam int ROW_W      = LOG2_DEPTH - 3;

   load_state_t       state;
   load_state_t       state_next;
   logic              restart;
   logic              accept;
   logic              ready_int;
   logic              busy_int;

   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  count;
   logic              error;
   logic              ptr_in_range;
   logic              wr_en;

   logic [ADDR_W-1:0] addr_q;
   logic              sampled_q;
   logic              fault_q;
   logic              fetch_fault;
   logic [ROW_W-1:0]  fetch_row;
   logic [7:0]        bank_rdata [NUM_BANKS];
   logic [INSTR_W-1:0] rotated;

   assign fetch_row    = bus.hatch_address[LOG2_DEPTH-1:3];
   assign ptr_in_range = (ptr >> LOG2_DEPTH) == '0;
   assign wr_en        = accept && ptr_in_range;

   // A window faults when any address bit above the memory is set or its last
   // byte runs past the end; the extra bit keeps A+5 from wrapping silently.
   assign fetch_fault = ((bus.hatch_address >> LOG2_DEPTH) != '0) ||
                        (({1'b0, bus.hatch_address} + (ADDR_W+1)'(INSTR_BYTES-1))
                         >= (ADDR_W+1)'(DEPTH_BYTES));

   // Each bank reads the starting row, or the next row when it lies below the
   // starting bank; the loader writes only the bank selected by ptr[2:0].
   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic             bank_we;
      logic [ROW_W-1:0] bank_raddr;

      assign bank_we    = wr_en && (ptr[2:0] == 3'(g));
      assign bank_raddr = fetch_row + ROW_W'(row_bump(3'(g), bus.hatch_address[2:0]));

      hatch_imem_bank #(
         .ROWS  (ROWS),
         .ROW_W (ROW_W)
      ) u_bank (
         .clk   (clk),
         .we    (bank_we),
         .waddr (ptr[LOG2_DEPTH-1:3]),
         .wdata (bus.load_data),
         .raddr (bank_raddr),
         .rdata (bank_rdata[g])
      );
   end

   // Fetch bookkeeping: remember which address the bank outputs belong to,
   // whether anything has been sampled since reset, and its fault status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         sampled_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         addr_q    <= bus.hatch_address;
         sampled_q <= 1'b1;
         fault_q   <= fetch_fault;
      end
   end

   // Rotate bank outputs so the byte at the sampled address lands in the top
   // byte and the following bytes fill downwards.
   always_comb begin
      rotated = '0;
      for (int i = 0; i < INSTR_BYTES; i++) begin
         rotated[(INSTR_BYTES-1-i)*8 +: 8] = bank_rdata[bank_index(addr_q[2:0], i)];
      end
   end

   // Until the first sample after reset, and on a faulting sample, the
   // instruction is forced to zero so stale RAM contents never escape.
   assign bus.hatch_instruction = (sampled_q && !fault_q) ? rotated : '0;
   assign bus.hatch_valid       = sampled_q && (addr_q == bus.hatch_address);
   assign bus.hatch_fault       = fault_q;

   // Loader state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Loader next-state and controls. A start pulse in LOAD wins over a byte
   // offered in the same cycle, which is dropped.
   always_comb begin
      state_next = state;
      restart    = 1'b0;
      accept     = 1'b0;
      ready_int  = 1'b0;
      busy_int   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.load_start) begin
               state_next = ST_LOAD;
               restart    = 1'b1;
            end
         end
         ST_LOAD: begin
            ready_int = 1'b1;
            busy_int  = 1'b1;
            if (bus.load_start) begin
               restart = 1'b1;
            end else if (bus.load_valid) begin
               accept = 1'b1;
               if (bus.load_last) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Loader datapath: pointer advances on every accepted byte even when the
   // write is suppressed, and the count saturates rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
         error <= 1'b0;
      end else if (restart) begin
         ptr   <= bus.load_base;
         count <= '0;
         error <= 1'b0;
      end else if (accept) begin
         ptr <= ptr + 1'b1;
         if (count != '1) begin
            count <= count + 1'b1;
         end
         if (!ptr_in_range) begin
            error <= 1'b1;
         end
      end
   end

   assign bus.load_ready = ready_int;
   assign bus.load_busy  = busy_int;
   assign bus.load_count = count;
   assign bus.load_error = error;

endmodule

// File: tb/tb_hatch_imem.sv
// ---------------------------------------------------------------------------
// tb_hatch_imem
// Directed plus randomized checks of hatch_imem against a byte-array model:
// a fetch returns the six model bytes at A unless A+5 reaches past memory.
// ---------------------------------------------------------------------------
module tb_hatch_imem;

   localparam int DEPTH   = 8192;
   localparam int CNT_W   = 12;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic rst;

   hatch_imem_if #(.ADDR_W(32), .CNT_W(CNT_W)) bus ();

   hatch_imem #(
      .ADDR_W      (32),
      .DEPTH_BYTES (DEPTH),
      .CNT_W       (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          compared;
   int          mismatched;
   logic [7:0]  model_mem [DEPTH];
   logic [31:0] model_ptr;
   int          model_count;
   logic        model_error;
   logic [7:0]  byte_q [$];
   logic [47:0] old_instr;

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_fault(input logic [31:0] a);
      return ({1'b0, a} + 33'd5) >= 33'(DEPTH);
   endfunction

   function automatic logic [47:0] model_instr(input logic [31:0] a);
      logic [47:0] r;
      r = '0;
      if (!model_fault(a)) begin
         for (int i = 0; i < 6; i++) begin
            r[(5-i)*8 +: 8] = model_mem[a + 32'(i)];
         end
      end
      return r;
   endfunction

   task automatic applyStimulus(input logic [31:0] a);
      bus.hatch_address = a;
   endtask

   // Fetch check for the address presented before the last edge.
   task automatic checkFetch(input string tag, input logic [31:0] a);
      checkOutput({tag, "_instr"}, 64'(bus.hatch_instruction), 64'(model_instr(a)));
      checkOutput({tag, "_fault"}, 64'(bus.hatch_fault), 64'(model_fault(a)));
      checkOutput({tag, "_valid"}, 64'(bus.hatch_valid), 64'd1);
   endtask

   task automatic startLoad(input logic [31:0] base);
      bus.load_start = 1'b1;
      bus.load_base  = base;
      tick();
      bus.load_start = 1'b0;
      model_ptr   = base;
      model_count = 0;
      model_error = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] d, input logic last);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      bus.load_last  = last;
      tick();
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      if (model_ptr < 32'(DEPTH)) model_mem[model_ptr] = d;
      else model_error = 1'b1;
      if (model_count < CNT_MAX) model_count++;
      model_ptr = model_ptr + 32'd1;
   endtask

   // Streams byte_q from base, with random idle gaps, last on the final byte.
   task automatic runLoad(input string tag, input logic [31:0] base, input int gap_pct);
      startLoad(base);
      checkOutput({tag, "_ready"}, 64'(bus.load_ready), 64'd1);
      checkOutput({tag, "_busy"}, 64'(bus.load_busy), 64'd1);
      for (int i = 0; i < byte_q.size(); i++) begin
         for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) tick();
         sendByte(byte_q[i], i == byte_q.size() - 1);
      end
   endtask

   task automatic checkLoadDone(input string tag);
      checkOutput({tag, "_count"}, 64'(bus.load_count), 64'(model_count));
      checkOutput({tag, "_error"}, 64'(bus.load_error), 64'(model_error));
      checkOutput({tag, "_ready0"}, 64'(bus.load_ready), 64'd0);
      checkOutput({tag, "_busy0"}, 64'(bus.load_busy), 64'd0);
   endtask

   initial begin
      logic [31:0] a;
      compared    = 0;
      mismatched  = 0;
      model_ptr   = '0;
      model_count = 0;
      model_error = 1'b0;
      rst = 1'b1;
      bus.hatch_address = '0;
      bus.load_start = 1'b0;
      bus.load_base  = '0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.load_last  = 1'b0;
      repeat (2) tick();

      checkOutput("rst_instr", 64'(bus.hatch_instruction), 64'd0);
      checkOutput("rst_valid", 64'(bus.hatch_valid), 64'd0);
      checkOutput("rst_fault", 64'(bus.hatch_fault), 64'd0);
      checkOutput("rst_ready", 64'(bus.load_ready), 64'd0);
      checkOutput("rst_busy", 64'(bus.load_busy), 64'd0);
      checkOutput("rst_count", 64'(bus.load_count), 64'd0);
      checkOutput("rst_error", 64'(bus.load_error), 64'd0);
      rst = 1'b0;
      tick();

      // Whole memory filled so every fetch is defined; count saturates.
      byte_q.delete();
      for (int i = 0; i < DEPTH; i++) byte_q.push_back(8'($urandom));
      runLoad("fill", 32'h0, 0);
      checkLoadDone("fill");
      checkOutput("fill_sat", 64'(bus.load_count), 64'(CNT_MAX));

      byte_q = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
      runLoad("ld0", 32'h0, 30);
      checkLoadDone("ld0");
      byte_q = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h10, 8'h01};
      runLoad("ld7", 32'h7, 30);
      byte_q = '{8'h01, 8'h01, 8'h13, 8'h37, 8'hD0, 8'h0D};
      runLoad("ldD", 32'hD, 30);
      checkLoadDone("ldD");

      applyStimulus(32'h0);
      tick();
      checkFetch("f00", 32'h0);
      checkOutput("f00_lit", 64'(bus.hatch_instruction), 64'h0A0000000007);
      applyStimulus(32'h7);
      #1;
      checkOutput("f07_drop", 64'(bus.hatch_valid), 64'd0);
      tick();
      checkFetch("f07", 32'h7);
      checkOutput("f07_lit", 64'(bus.hatch_instruction), 64'h010100001001);
      applyStimulus(32'hD);
      #1;
      checkOutput("f0D_drop", 64'(bus.hatch_valid), 64'd0);
      tick();
      checkFetch("f0D", 32'hD);
      checkOutput("f0D_lit", 64'(bus.hatch_instruction), 64'h01011337D00D);

      applyStimulus(32'h1FFC);
      tick();
      checkFetch("f1FFC", 32'h1FFC);
      checkOutput("f1FFC_fault", 64'(bus.hatch_fault), 64'd1);
      applyStimulus(32'h1FFB);
      tick();
      checkFetch("f1FFB", 32'h1FFB);
      applyStimulus(32'h1FFA);
      tick();
      checkFetch("f1FFA", 32'h1FFA);
      checkOutput("f1FFA_fault", 64'(bus.hatch_fault), 64'd0);
      applyStimulus(32'hFFFF_FFFE);
      tick();
      checkFetch("fwrap", 32'hFFFF_FFFE);

      byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      runLoad("lderr", 32'h1FFE, 0);
      checkLoadDone("lderr");
      checkOutput("lderr_cnt4", 64'(bus.load_count), 64'd4);
      checkOutput("lderr_err1", 64'(bus.load_error), 64'd1);
      applyStimulus(32'h1FFA);
      tick();
      checkFetch("ferr", 32'h1FFA);
      checkOutput("ferr_tail", 64'(bus.hatch_instruction[15:0]), 64'hAABB);

      // Read-before-write: fetch window 0x20 while byte 0x22 is rewritten.
      byte_q = '{8'hA5};
      runLoad("ldpre", 32'h22, 0);
      applyStimulus(32'h20);
      tick();
      checkFetch("coll_pre", 32'h20);
      old_instr = model_instr(32'h20);
      byte_q = '{8'h55};
      runLoad("ldcoll", 32'h22, 0);
      checkOutput("coll_same", 64'(bus.hatch_instruction), 64'(old_instr));
      tick();
      checkFetch("coll_next", 32'h20);
      checkOutput("coll_byte", 64'(bus.hatch_instruction[31:24]), 64'h55);

      // Restart mid-load; the byte offered with the restart pulse is dropped.
      startLoad(32'h100);
      sendByte(8'h11, 1'b0);
      sendByte(8'h22, 1'b0);
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hEE;
      startLoad(32'h200);
      bus.load_valid = 1'b0;
      sendByte(8'h33, 1'b0);
      sendByte(8'h44, 1'b0);
      sendByte(8'h66, 1'b1);
      checkLoadDone("restart");
      checkOutput("restart_cnt3", 64'(bus.load_count), 64'd3);
      applyStimulus(32'h100);
      tick();
      checkFetch("f100", 32'h100);
      applyStimulus(32'h1FE);
      tick();
      checkFetch("f1FE", 32'h1FE);

      // Reset after three bytes of a load.
      startLoad(32'h300);
      sendByte(8'h9A, 1'b0);
      sendByte(8'hBC, 1'b0);
      sendByte(8'hDE, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("mrst_busy", 64'(bus.load_busy), 64'd0);
      checkOutput("mrst_ready", 64'(bus.load_ready), 64'd0);
      checkOutput("mrst_count", 64'(bus.load_count), 64'd0);
      checkOutput("mrst_error", 64'(bus.load_error), 64'd0);
      checkOutput("mrst_valid", 64'(bus.hatch_valid), 64'd0);
      checkOutput("mrst_instr", 64'(bus.hatch_instruction), 64'd0);
      tick();
      rst = 1'b0;
      applyStimulus(32'h300);
      tick();
      checkFetch("f300", 32'h300);
      checkOutput("f300_lit", 64'(bus.hatch_instruction[47:24]), 64'h9ABCDE);

      // Random loads, then random fetches over memory and beyond it.
      for (int n = 0; n < 6; n++) begin
         byte_q.delete();
         for (int i = 0; i < int'($urandom_range(1, 8)); i++) byte_q.push_back(8'($urandom));
         a = 32'($urandom_range(0, DEPTH - 1));
         runLoad("ldrnd", a, 30);
         checkLoadDone("ldrnd");
      end
      for (int n = 0; n < 40; n++) begin
         a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
         applyStimulus(a);
         tick();
         checkFetch("frnd", a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hatch_imem.md
Name: hatch_imem

Overview:
- Byte-addressed instruction memory that sits on the responder side of the hatch fetch interface.
- The cpu drives hatch_address; this block returns the 6 bytes at that address as hatch_instruction.
- It also provides a streaming byte loader, so a bench or boot controller can write a program image without hierarchical pokes.
- Replaces hand-coded wait/assign instruction sequencing in simulation and becomes the fetch store in synthesis.

Parameters:
- ADDR_W, 32, width of hatch_address and load_base.
- DEPTH_BYTES, 8192, memory size in bytes; must be a power of two and a multiple of 8.
- CNT_W, 16, width of load_count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- hatch_address  in  ADDR_W  byte address of the instruction to fetch
- hatch_instruction  out  48  byte at hatch_address in [47:40], then ascending bytes down to [7:0]
- hatch_valid  out  1  hatch_instruction corresponds to the current hatch_address
- hatch_fault  out  1  fetched window exceeds DEPTH_BYTES
- load_start  in  1  single-cycle pulse; latch load_base and enter LOAD
- load_base  in  ADDR_W  first byte address for the load
- load_valid  in  1  load_data present
- load_data  in  8  byte to write
- load_last  in  1  qualifies the final byte of the image
- load_ready  out  1  block accepts a byte this cycle
- load_busy  out  1  FSM is in LOAD
- load_count  out  CNT_W  bytes written in current or last load
- load_error  out  1  sticky; a write fell outside memory

Behaviour:
- Reset values: hatch_instruction=0, hatch_valid=0, hatch_fault=0, load_ready=0, load_busy=0, load_count=0, load_error=0, FSM=IDLE.
- Reset does not clear memory contents.
- Storage: 8 byte-banks of DEPTH_BYTES/8 entries each. Byte a lives in bank a[2:0], row a>>3.
- Fetch, 1-cycle latency:
  - At each edge, sample hatch_address as A.
  - Each bank b reads row (A>>3) if b >= A[2:0], else row (A>>3)+1.
  - Rotate the bank outputs combinationally so byte A lands in [47:40] and A+5 in [7:0].
  - hatch_instruction is valid after the first edge that samples A.
  - hatch_valid = sampled-since-reset AND (A == current hatch_address). It drops combinationally when the address changes and rises again one edge later.
- Fault: if A+5 >= DEPTH_BYTES, or any address bit at or above log2(DEPTH_BYTES) is set, then hatch_fault=1 and hatch_instruction=0 for that sample. A fault does not affect hatch_valid.
- Loader FSM, states IDLE and LOAD:
  - IDLE: load_ready=0. load_start moves to LOAD, sets ptr=load_base and load_count=0, and clears load_error.
  - LOAD: load_ready=1 and load_busy=1.
  - Each cycle with load_valid: write load_data to ptr, ptr+1, load_count+1.
  - If ptr >= DEPTH_BYTES: suppress the write, set load_error, but still increment the count.
  - load_valid with load_last: return to IDLE after this byte.
  - load_start while in LOAD restarts the load from the new base; any in-flight byte that cycle is dropped.
- load_count saturates at all-ones.
- Same-edge collision: a fetch read and a loader write to the same byte return the old data (read-before-write). The new data is visible from the next sample.
- Reset mid-load: FSM returns to IDLE and bytes already written remain. load_count and load_error are cleared.
- Address arithmetic wraps modulo 2^ADDR_W. Wrapped addresses are out of range, so they fault.

Decomposition:
- Shared package holds INSTR_BYTES=6, NUM_BANKS=8, the loader state encoding, and the bank index/row helper functions.
- One sub-module, hatch_imem_bank: single-port-write / single-port-read synchronous byte RAM, instantiated 8 times.
- The top level holds the rotate network, fault logic and loader FSM.

Test Plan:
- Load at base 0x00 the bytes 0A 00 00 00 00 07, then present hatch_address 0x0 -> one edge later hatch_instruction=48'h0A0000000007, hatch_valid=1, hatch_fault=0.
- Load base 0x07 bytes 01 01 00 00 10 01 (crosses bank 7 to bank 0) and base 0x0D bytes 01 01 13 37 D0 0D. Fetch 0x07 -> 48'h010100001001. Fetch 0x0D -> 48'h01011337D00D. hatch_valid drops for exactly the cycle in which the address changed.
- hatch_address 0x1FFC (window ends at 0x2001, DEPTH 8192) -> hatch_fault=1, hatch_instruction=0. hatch_address 0x1FFA -> fault=0.
- Load base 0x1FFE with 4 bytes AA BB CC DD, last on DD -> load_count=4, load_error=1. 0x1FFE/0x1FFF hold AA/BB. FSM back in IDLE, load_ready=0.
- Hold hatch_address 0x20 while the loader writes 0x55 to 0x22 -> same-cycle output shows the old byte, next cycle shows 0x55 in [31:24].
- Assert rst after 3 bytes of a load -> load_busy=0, load_count=0, hatch_valid=0. Those 3 bytes are still fetchable after reset.
